rv0_ahb_arb: RTL and testbench

AHB-Lite master-port arbiter and sequencer for the rv0 core. It shares one AHB-Lite master interface between the instruction-fetch requester (IF) and the load/store unit requester (LS). Each side uses a simple valid/ready request and a response pulse. The block arbitrates, performs single NONSEQ transfers with one transfer outstanding, checks alignment, and returns read data or an error.

---
 rtl/rv0_ahb_arb_if.sv | 30 +++
 rtl/rv0_ahb_arb.sv | 145 ++++++++++++++
 tb/tb_rv0_ahb_arb.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/rv0_ahb_arb_if.sv
// AHB-Lite master-side bus bundle shared by the rv0 arbiter and its slave.
// The master modport drives the address/data phase; the slave answers with ready/data/resp.
interface rv0_ahb_arb_if #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int HPROT_WIDTH   = 4,
  parameter int HMASTER_WIDTH = 1
) ();
  logic [ADDR_WIDTH-1:0]    haddr;
  logic [1:0]               htrans;
  logic                     hwrite;
  logic [2:0]               hsize;
  logic [2:0]               hburst;
  logic [HPROT_WIDTH-1:0]   hprot;
  logic [HMASTER_WIDTH-1:0] hmaster;
  logic [DATA_WIDTH-1:0]    hwdata;
  logic                     hready;
  logic [DATA_WIDTH-1:0]    hrdata;
  logic                     hresp;

  modport master (
    output haddr, htrans, hwrite, hsize, hburst, hprot, hmaster, hwdata,
    input  hready, hrdata, hresp
  );

  modport slave (
    input  haddr, htrans, hwrite, hsize, hburst, hprot, hmaster, hwdata,
    output hready, hrdata, hresp
  );
endinterface

// File: rtl/rv0_ahb_arb.sv
// Shares one AHB-Lite master port between instruction fetch and the LSU.
// Single NONSEQ transfers, one outstanding; misaligned requests are answered locally with an error.
module rv0_ahb_arb #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int HPROT_WIDTH   = 4,
  parameter int HMASTER_WIDTH = 1,
  parameter bit ARB_RR        = 1'b1
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_rsp_valid,
  output logic [DATA_WIDTH-1:0] if_rsp_rdata,
  output logic                  if_rsp_err,
  input  logic                  ls_req_valid,
  output logic                  ls_req_ready,
  input  logic [ADDR_WIDTH-1:0] ls_req_addr,
  input  logic                  ls_req_we,
  input  logic [2:0]            ls_req_size,
  input  logic [DATA_WIDTH-1:0] ls_req_wdata,
  output logic                  ls_rsp_valid,
  output logic [DATA_WIDTH-1:0] ls_rsp_rdata,
  output logic                  ls_rsp_err,
  rv0_ahb_arb_if.master         ahb
);
  localparam logic [2:0] MAX_SZ      = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [1:0] HT_IDLE     = 2'b00;
  localparam logic [1:0] HT_NONSEQ   = 2'b10;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ERRRSP} state_e;

  state_e                r_state, w_next;
  logic                  r_last_ls;
  logic                  r_owner_ls;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [2:0]            r_size;
  logic [HPROT_WIDTH-1:0] r_hprot;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_if_rsp_valid, r_ls_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  logic                  w_gnt_ls, w_gnt_if, w_acc, w_mis;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [2:0]            w_size;
  logic [2:0]            w_lowmask;

  // Round-robin hands a tie to whoever did not win last time.
  always_comb begin
    w_gnt_ls = ARB_RR ? (ls_req_valid && (!if_req_valid || !r_last_ls)) : ls_req_valid;
    w_gnt_if = if_req_valid && !w_gnt_ls;
    w_acc    = (r_state == S_IDLE) && (w_gnt_if || w_gnt_ls);
    w_addr   = w_gnt_ls ? ls_req_addr : if_req_addr;
    w_size   = w_gnt_ls ? ls_req_size : HSIZE_WORD;
    case (w_size)
      3'd0:    w_lowmask = 3'b000;
      3'd1:    w_lowmask = 3'b001;
      3'd2:    w_lowmask = 3'b011;
      default: w_lowmask = 3'b111;
    endcase
    w_mis = (w_size > MAX_SZ) || (|(w_addr[2:0] & w_lowmask));
  end

  assign if_req_ready = (r_state == S_IDLE) && w_gnt_if;
  assign ls_req_ready = (r_state == S_IDLE) && w_gnt_ls;

  always_ff @(posedge hclk) begin
    if (!hresetn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_acc) w_next = w_mis ? S_ERRRSP : S_ADDR;
      S_ADDR:   if (ahb.hready) w_next = S_DATA;
      S_DATA:   if (ahb.hready) w_next = S_IDLE;
      S_ERRRSP: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Completion is only ever sampled with hready high, so the first cycle of a
  // two-cycle error response is naturally ignored.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_last_ls      <= 1'b1;
      r_owner_ls     <= 1'b0;
      r_addr         <= '0;
      r_we           <= 1'b0;
      r_size         <= '0;
      r_hprot        <= '0;
      r_wdata        <= '0;
      r_if_rsp_valid <= 1'b0;
      r_ls_rsp_valid <= 1'b0;
      r_rsp_rdata    <= '0;
      r_rsp_err      <= 1'b0;
    end else begin
      r_if_rsp_valid <= 1'b0;
      r_ls_rsp_valid <= 1'b0;
      if (w_acc) begin
        r_last_ls  <= w_gnt_ls;
        r_owner_ls <= w_gnt_ls;
        r_addr     <= w_addr;
        r_we       <= w_gnt_ls && ls_req_we;
        r_size     <= w_size;
        r_hprot    <= HPROT_WIDTH'(w_gnt_ls ? 4'b0011 : 4'b0010);
        r_wdata    <= (w_gnt_ls && ls_req_we) ? ls_req_wdata : '0;
      end
      if (r_state == S_DATA && ahb.hready) begin
        r_if_rsp_valid <= !r_owner_ls;
        r_ls_rsp_valid <= r_owner_ls;
        r_rsp_rdata    <= r_we ? '0 : ahb.hrdata;
        r_rsp_err      <= ahb.hresp;
      end
      if (r_state == S_ERRRSP) begin
        r_if_rsp_valid <= !r_owner_ls;
        r_ls_rsp_valid <= r_owner_ls;
        r_rsp_rdata    <= '0;
        r_rsp_err      <= 1'b1;
      end
    end
  end

  assign ahb.htrans  = (r_state == S_ADDR) ? HT_NONSEQ : HT_IDLE;
  assign ahb.haddr   = r_addr;
  assign ahb.hwrite  = r_we;
  assign ahb.hsize   = r_size;
  assign ahb.hburst  = 3'b000;
  assign ahb.hprot   = r_hprot;
  assign ahb.hmaster = HMASTER_WIDTH'(r_owner_ls);
  assign ahb.hwdata  = (r_state == S_DATA) ? r_wdata : '0;

  assign if_rsp_valid = r_if_rsp_valid;
  assign if_rsp_rdata = r_rsp_rdata;
  assign if_rsp_err   = r_rsp_err;
  assign ls_rsp_valid = r_ls_rsp_valid;
  assign ls_rsp_rdata = r_rsp_rdata;
  assign ls_rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_rv0_ahb_arb.sv
// Random-stimulus bench for rv0_ahb_arb: each accepted request gets a pre-drawn slave
// timeline (address waits, data waits, error) from which every bus and response cycle is predicted.
module tb_rv0_ahb_arb;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int NCYC = 1500;

  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  always #5 hclk = ~hclk;

  logic          if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
  logic [AW-1:0] if_req_addr;
  logic [DW-1:0] if_rsp_rdata;
  logic          ls_req_valid, ls_req_ready, ls_req_we, ls_rsp_valid, ls_rsp_err;
  logic [AW-1:0] ls_req_addr;
  logic [2:0]    ls_req_size;
  logic [DW-1:0] ls_req_wdata, ls_rsp_rdata;

  logic          fx_if_req_valid, fx_if_req_ready, fx_if_rsp_valid, fx_if_rsp_err;
  logic [AW-1:0] fx_if_req_addr;
  logic [DW-1:0] fx_if_rsp_rdata;
  logic          fx_ls_req_valid, fx_ls_req_ready, fx_ls_req_we, fx_ls_rsp_valid, fx_ls_rsp_err;
  logic [AW-1:0] fx_ls_req_addr;
  logic [2:0]    fx_ls_req_size;
  logic [DW-1:0] fx_ls_req_wdata, fx_ls_rsp_rdata;

  rv0_ahb_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HPROT_WIDTH(4), .HMASTER_WIDTH(1)) bus ();
  rv0_ahb_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HPROT_WIDTH(4), .HMASTER_WIDTH(1)) fxb ();

  rv0_ahb_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HPROT_WIDTH(4), .HMASTER_WIDTH(1), .ARB_RR(1'b1)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata), .if_rsp_err(if_rsp_err),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
    .ls_req_we(ls_req_we), .ls_req_size(ls_req_size), .ls_req_wdata(ls_req_wdata),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_rdata(ls_rsp_rdata), .ls_rsp_err(ls_rsp_err),
    .ahb(bus.master)
  );

  rv0_ahb_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HPROT_WIDTH(4), .HMASTER_WIDTH(1), .ARB_RR(1'b0)) u_fix (
    .hclk(hclk), .hresetn(hresetn),
    .if_req_valid(fx_if_req_valid), .if_req_ready(fx_if_req_ready), .if_req_addr(fx_if_req_addr),
    .if_rsp_valid(fx_if_rsp_valid), .if_rsp_rdata(fx_if_rsp_rdata), .if_rsp_err(fx_if_rsp_err),
    .ls_req_valid(fx_ls_req_valid), .ls_req_ready(fx_ls_req_ready), .ls_req_addr(fx_ls_req_addr),
    .ls_req_we(fx_ls_req_we), .ls_req_size(fx_ls_req_size), .ls_req_wdata(fx_ls_req_wdata),
    .ls_rsp_valid(fx_ls_rsp_valid), .ls_rsp_rdata(fx_ls_rsp_rdata), .ls_rsp_err(fx_ls_rsp_err),
    .ahb(fxb.master)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference state
  bit          have, t_mis, t_we, t_err, rst_chk, mid_rst_done, if_acc, ls_acc, exp_ns, exp_rsp;
  int          t_owner, ns_lo, ns_hi, d_lo, d_hi, t_rsp, free_at, last, ntx, win, aw, dw, p, fx_next;
  logic [31:0] t_addr, t_wdata, t_rdata, exp_rd, tmp;
  logic [2:0]  t_size;

  initial begin
    if_req_valid = 0; if_req_addr = '0;
    ls_req_valid = 0; ls_req_addr = '0; ls_req_we = 0; ls_req_size = 3'd0; ls_req_wdata = '0;
    bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = '0;
    fx_if_req_valid = 1; fx_if_req_addr = 32'h40;
    fx_ls_req_valid = 1; fx_ls_req_addr = 32'h100; fx_ls_req_we = 0;
    fx_ls_req_size = 3'd2; fx_ls_req_wdata = '0;
    fxb.hready = 1'b1; fxb.hresp = 1'b0; fxb.hrdata = 32'h5a;
    have = 0; t_mis = 0; t_we = 0; t_err = 0; mid_rst_done = 0; if_acc = 0; ls_acc = 0;
    t_owner = 0; ns_lo = 0; ns_hi = -1; d_lo = 0; d_hi = -1; t_rsp = -1; ntx = 0;
    t_addr = '0; t_wdata = '0; t_rdata = '0; t_size = '0;
    hresetn = 0;
    repeat (3) @(posedge hclk);
    free_at = 0; last = 1; rst_chk = 1; fx_next = 0;

    for (int c = 0; c < NCYC; c++) begin
      @(posedge hclk); #1;
      hresetn = 1'b1;
      if (if_acc) begin if_req_valid = 0; if_acc = 0; end
      if (ls_acc) begin ls_req_valid = 0; ls_acc = 0; end
      p = (c < 200) ? 100 : 35;
      if (!if_req_valid && $urandom_range(0, 99) < p) begin
        tmp = $urandom;
        if_req_addr  = ($urandom_range(0, 7) == 0) ? tmp : (tmp & ~32'h3);
        if_req_valid = 1;
      end
      if (!ls_req_valid && $urandom_range(0, 99) < p) begin
        ls_req_we    = 1'($urandom_range(0, 1));
        ls_req_size  = 3'($urandom_range(0, 3));
        ls_req_wdata = $urandom;
        tmp = $urandom;
        ls_req_addr  = ($urandom_range(0, 3) == 0) ? tmp : (tmp & ~((32'd1 << ls_req_size) - 1));
        ls_req_valid = 1;
      end
      bus.hresp  = 1'b0;
      bus.hrdata = $urandom;
      bus.hready = 1'($urandom_range(0, 1));
      if (have && !t_mis) begin
        if (c >= ns_lo && c <= ns_hi) bus.hready = (c == ns_hi);
        else if (c >= d_lo && c <= d_hi) begin
          bus.hready = (c == d_hi);
          bus.hresp  = t_err && (c >= d_hi - 1);
          if (c == d_hi) bus.hrdata = t_rdata;
        end
      end
      if (!mid_rst_done && ntx >= 15 && have && !t_mis && c >= d_lo && c < d_hi) begin
        hresetn = 1'b0;
        mid_rst_done = 1;
      end

      @(negedge hclk);
      if (rst_chk) begin
        chk("rst_htrans", bus.htrans, 0);   chk("rst_haddr", bus.haddr, 0);
        chk("rst_hwrite", bus.hwrite, 0);   chk("rst_hsize", bus.hsize, 0);
        chk("rst_hprot", bus.hprot, 0);     chk("rst_hmaster", bus.hmaster, 0);
        chk("rst_hwdata", bus.hwdata, 0);
        chk("rst_if_rsp", {if_rsp_valid, if_rsp_err, if_rsp_rdata}, 0);
        chk("rst_ls_rsp", {ls_rsp_valid, ls_rsp_err, ls_rsp_rdata}, 0);
        rst_chk = 0;
      end
      exp_ns = have && !t_mis && c >= ns_lo && c <= ns_hi;
      chk("htrans", bus.htrans, exp_ns ? 2 : 0);
      if (exp_ns) begin
        chk("haddr", bus.haddr, t_addr);   chk("hwrite", bus.hwrite, t_we);
        chk("hsize", bus.hsize, t_size);   chk("hburst", bus.hburst, 0);
        chk("hprot", bus.hprot, (t_owner == 1) ? 3 : 2);
        chk("hmaster", bus.hmaster, t_owner);
      end
      if (have && !t_mis && c >= d_lo && c <= d_hi) chk("hwdata", bus.hwdata, t_we ? t_wdata : 0);
      exp_rsp = have && (c == t_rsp);
      chk("if_rsp_valid", if_rsp_valid, exp_rsp && t_owner == 0);
      chk("ls_rsp_valid", ls_rsp_valid, exp_rsp && t_owner == 1);
      if (exp_rsp) begin
        exp_rd = (t_mis || t_we) ? 32'd0 : t_rdata;
        if (t_owner == 0) begin
          chk("if_rsp_rdata", if_rsp_rdata, exp_rd); chk("if_rsp_err", if_rsp_err, t_mis || t_err);
        end else begin
          chk("ls_rsp_rdata", ls_rsp_rdata, exp_rd); chk("ls_rsp_err", ls_rsp_err, t_mis || t_err);
        end
      end
      win = -1;
      if (c >= free_at) begin
        if (if_req_valid && ls_req_valid) win = (last == 1) ? 0 : 1;
        else if (if_req_valid) win = 0;
        else if (ls_req_valid) win = 1;
      end
      chk("if_req_ready", if_req_ready, win == 0);
      chk("ls_req_ready", ls_req_ready, win == 1);
      if (!hresetn) begin
        have = 0; last = 1; free_at = c + 1; rst_chk = 1;
      end else if (win >= 0) begin
        t_owner = win;
        t_addr  = (win == 1) ? ls_req_addr : if_req_addr;
        t_size  = (win == 1) ? ls_req_size : 3'd2;
        t_we    = (win == 1) && ls_req_we;
        t_wdata = t_we ? ls_req_wdata : 32'd0;
        t_mis   = (t_size > 3'd2) || ((t_addr & ((32'd1 << t_size) - 1)) != 0);
        if (t_mis) begin
          t_err = 0; t_rsp = c + 2; ns_lo = 0; ns_hi = -1; d_lo = 0; d_hi = -1;
        end else begin
          aw = $urandom_range(0, 2); dw = $urandom_range(0, 2);
          t_err = ($urandom_range(0, 4) == 0);
          if (t_err && dw == 0) dw = 1;
          ns_lo = c + 1; ns_hi = c + 1 + aw; d_lo = ns_hi + 1; d_hi = d_lo + dw;
          t_rsp = d_hi + 1; t_rdata = $urandom;
        end
        free_at = t_rsp; have = 1; last = win; ntx++;
        if (win == 0) if_acc = 1; else ls_acc = 1;
      end

      // Fixed-priority instance: LS never lets go, so IF must starve.
      chk("fx_if_ready", fx_if_req_ready, 0);
      chk("fx_ls_ready", fx_ls_req_ready, c == fx_next);
      if (fxb.htrans == 2'b10) chk("fx_hmaster", fxb.hmaster, 1);
      if (!hresetn) fx_next = c + 1;
      else if (c == fx_next) fx_next = c + 3;
    end

    chk("mid_rst_hit", mid_rst_done, 1);
    chk("tx_count", ntx > 100, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
